// File: rtl/shift_register_universal.sv
`default_nettype none
// ============================================================================
// Module   : shift_register_universal
// Purpose  : Parameterized universal shift register with shift left, shift
//            right, rotate left and parallel load, a serial in/out pair and a
//            word-complete carry pulse (RCO) every WIDTH enabled shifts.
// Ports    : CLK    - clock, rising edge
//            RST_N  - asynchronous active-low reset
//            ENB    - enable; when low Q, counter and S_OUT hold
//            MODO   - 00 shl, 01 shr, 10 rotl, 11 parallel load
//            D      - parallel load data
//            S_IN   - serial input bit for shifts
//            Q      - register contents (registered)
//            S_OUT  - bit shifted/rotated out on last enabled shift
//            RCO    - one-cycle pulse after the WIDTH-th counted shift
// Revision : 1.0 - initial release
// ============================================================================
module shift_register_universal #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] D,
  input  logic             S_IN,
  output logic [WIDTH-1:0] Q,
  output logic             S_OUT,
  output logic             RCO
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] c_MODE_SHL  = 2'b00;
  localparam logic [1:0] c_MODE_SHR  = 2'b01;
  localparam logic [1:0] c_MODE_ROTL = 2'b10;
  localparam logic [1:0] c_MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] q_q,    q_d;
  logic             sout_q, sout_d;
  logic             rco_q,  rco_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    cnt_d  = cnt_q;
    rco_d  = 1'b0;

    if (ENB) begin
      if (MODO == c_MODE_LOAD) begin
        // A load starts a fresh word; any partial count is discarded.
        q_d    = D;
        sout_d = 1'b0;
        cnt_d  = '0;
      end else begin
        case (MODO)
          c_MODE_SHL: begin
            q_d    = {q_q[WIDTH-2:0], S_IN};
            sout_d = q_q[WIDTH-1];
          end
          c_MODE_SHR: begin
            q_d    = {S_IN, q_q[WIDTH-1:1]};
            sout_d = q_q[0];
          end
          default: begin  // rotate left
            q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            sout_d = q_q[WIDTH-1];
          end
        endcase

        // All three shift flavours count toward the same word.
        if (cnt_q == c_CNT_LAST) begin
          cnt_d = '0;
          rco_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_q    <= '0;
      sout_q <= 1'b0;
      rco_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
      rco_q  <= rco_d;
      cnt_q  <= cnt_d;
    end
  end

  assign Q     = q_q;
  assign S_OUT = sout_q;
  assign RCO   = rco_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_register_universal.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_register_universal
// Purpose  : Directed, table-driven self-checking bench for the four-bit
//            configuration of shift_register_universal.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_register_universal;

  logic       CLK;
  logic       RST_N;
  logic       ENB;
  logic [1:0] MODO;
  logic [3:0] D;
  logic       S_IN;
  logic [3:0] Q;
  logic       S_OUT;
  logic       RCO;

  int n_total;
  int n_pass;

  typedef struct {
    logic       enb;
    logic [1:0] modo;
    logic [3:0] d;
    logic       s_in;
    logic [3:0] q;
    logic       so;
    logic       rco;
  } vec_t;

  vec_t vq[$];

  shift_register_universal #(.WIDTH(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .ENB   (ENB),
    .MODO  (MODO),
    .D     (D),
    .S_IN  (S_IN),
    .Q     (Q),
    .S_OUT (S_OUT),
    .RCO   (RCO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one set of inputs, take one rising edge, then check all outputs.
  task automatic step(input string tag, input logic enb, input logic [1:0] modo,
                      input logic [3:0] d, input logic s_in,
                      input logic [3:0] eq, input logic eso, input logic erco);
    ENB  = enb;
    MODO = modo;
    D    = d;
    S_IN = s_in;
    @(posedge CLK);
    #1;
    chk({tag, ".Q"},     Q,            eq);
    chk({tag, ".S_OUT"}, {3'b0, S_OUT}, {3'b0, eso});
    chk({tag, ".RCO"},   {3'b0, RCO},   {3'b0, erco});
  endtask

  task automatic add(input logic enb, input logic [1:0] modo, input logic [3:0] d,
                     input logic s_in, input logic [3:0] q, input logic so, input logic rco);
    vec_t v;
    v.enb = enb; v.modo = modo; v.d = d; v.s_in = s_in;
    v.q = q; v.so = so; v.rco = rco;
    vq.push_back(v);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;

    // Load then shift left, S_IN=0
    add(1, 2'b11, 4'b1011, 0, 4'b1011, 0, 0);
    add(1, 2'b00, 4'b0000, 0, 4'b0110, 1, 0);
    add(1, 2'b00, 4'b0000, 0, 4'b1100, 0, 0);
    add(1, 2'b00, 4'b0000, 0, 4'b1000, 1, 0);
    add(1, 2'b00, 4'b0000, 0, 4'b0000, 1, 1);
    add(0, 2'b00, 4'b0000, 0, 4'b0000, 1, 0);
    // Rotate left, two words back-to-back
    add(1, 2'b11, 4'b1001, 0, 4'b1001, 0, 0);
    add(1, 2'b10, 4'b0000, 1, 4'b0011, 1, 0);
    add(1, 2'b10, 4'b0000, 1, 4'b0110, 0, 0);
    add(1, 2'b10, 4'b0000, 1, 4'b1100, 0, 0);
    add(1, 2'b10, 4'b0000, 1, 4'b1001, 1, 1);
    add(1, 2'b10, 4'b0000, 0, 4'b0011, 1, 0);
    add(1, 2'b10, 4'b0000, 0, 4'b0110, 0, 0);
    add(1, 2'b10, 4'b0000, 0, 4'b1100, 0, 0);
    add(1, 2'b10, 4'b0000, 0, 4'b1001, 1, 1);
    // Shift right S_IN=1 with an enable gap
    add(1, 2'b11, 4'b0000, 0, 4'b0000, 0, 0);
    add(1, 2'b01, 4'b0000, 1, 4'b1000, 0, 0);
    add(1, 2'b01, 4'b0000, 1, 4'b1100, 0, 0);
    add(0, 2'b01, 4'b0000, 1, 4'b1100, 0, 0);
    add(0, 2'b01, 4'b0000, 1, 4'b1100, 0, 0);
    add(0, 2'b01, 4'b0000, 1, 4'b1100, 0, 0);
    add(1, 2'b01, 4'b0000, 1, 4'b1110, 0, 0);
    add(1, 2'b01, 4'b0000, 1, 4'b1111, 0, 1);
    // Load mid-word after 3 shifts
    add(1, 2'b00, 4'b0000, 1, 4'b1111, 1, 0);
    add(1, 2'b00, 4'b0000, 1, 4'b1111, 1, 0);
    add(1, 2'b00, 4'b0000, 1, 4'b1111, 1, 0);
    add(1, 2'b11, 4'b0101, 0, 4'b0101, 0, 0);
    add(1, 2'b00, 4'b0000, 0, 4'b1010, 0, 0);
    add(1, 2'b00, 4'b0000, 0, 4'b0100, 1, 0);
    add(1, 2'b00, 4'b0000, 0, 4'b1000, 0, 0);
    add(1, 2'b00, 4'b0000, 0, 4'b0000, 1, 1);
    // Mixed modes share one count
    add(1, 2'b01, 4'b0000, 1, 4'b1000, 0, 0);
    add(1, 2'b10, 4'b0000, 0, 4'b0001, 1, 0);
    add(1, 2'b00, 4'b0000, 0, 4'b0010, 0, 0);
    add(1, 2'b01, 4'b0000, 0, 4'b0001, 0, 1);
    // Disabled load is ignored
    add(0, 2'b11, 4'b1111, 0, 4'b0001, 0, 0);

    // Power-on reset, then asynchronous reset with no clock edge
    RST_N = 1'b0;
    ENB   = 1'b1;
    MODO  = 2'b11;
    D     = 4'b1010;
    S_IN  = 1'b0;
    #12 RST_N = 1'b1;
    @(posedge CLK);
    #1;
    step("preload", 1, 2'b11, 4'b1010, 0, 4'b1010, 0, 0);
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst.Q",     Q,             4'b0000);
    chk("async_rst.S_OUT", {3'b0, S_OUT}, 4'b0000);
    chk("async_rst.RCO",   {3'b0, RCO},   4'b0000);
    #1 RST_N = 1'b1;

    foreach (vq[i]) begin
      step($sformatf("vec%0d", i), vq[i].enb, vq[i].modo, vq[i].d, vq[i].s_in,
           vq[i].q, vq[i].so, vq[i].rco);
    end

    // Reset mid-word: two shifts, async reset, then a full word is needed
    step("rmw_sh1", 1, 2'b00, 4'b0000, 1, 4'b0011, 0, 0);
    step("rmw_sh2", 1, 2'b00, 4'b0000, 1, 4'b0111, 0, 0);
    #2 RST_N = 1'b0;
    #1;
    chk("rmw_rst.Q",     Q,             4'b0000);
    chk("rmw_rst.S_OUT", {3'b0, S_OUT}, 4'b0000);
    #1 RST_N = 1'b1;
    step("rmw_a", 1, 2'b00, 4'b0000, 1, 4'b0001, 0, 0);
    step("rmw_b", 1, 2'b00, 4'b0000, 1, 4'b0011, 0, 0);
    step("rmw_c", 1, 2'b00, 4'b0000, 1, 4'b0111, 0, 0);
    step("rmw_d", 1, 2'b00, 4'b0000, 1, 4'b1111, 0, 1);
    step("rmw_e", 0, 2'b00, 4'b0000, 1, 4'b1111, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_register_universal.md
# shift_register_universal

Parameterized universal shift register: the device under test that the existing four-bit register bench drives and monitors through `CLK`, `ENB`, `MODO`, `D`, `Q` and `RCO`. It supports shift left, shift right, rotate left and parallel load, all selected by `MODO`. It adds a serial port pair, `S_IN` and `S_OUT`. `RCO` is a word-complete carry: it pulses once every `WIDTH` enabled shifts after a load.

## Interface
- `WIDTH`, default 4: register width in bits, ≥ 2.
- `CLK`  in  1: single clock; all state updates on the rising edge.
- `RST_N`  in  1: reset, asynchronous, active-low.
- `ENB`  in  1: enable. When 0, `Q`, the counter and `S_OUT` hold.
- `MODO`  in  2: 00 shift left, 01 shift right, 10 rotate left, 11 parallel load.
- `D`  in  WIDTH: parallel load data.
- `S_IN`  in  1: serial input bit for shifts.
- `Q`  out  WIDTH: register contents (registered).
- `S_OUT`  out  1: bit that left the register on the last enabled shift or rotate (registered).
- `RCO`  out  1: one-cycle pulse after the WIDTH-th enabled shift or rotate since the last load or reset (registered).

## Operation
- **Reset** (`RST_N`=0, immediate, independent of `CLK`):
  - `Q` = 0, `S_OUT` = 0, `RCO` = 0.
  - Internal shift counter `cnt` (⌈log2 WIDTH⌉+1 bits) = 0.
- **`ENB`=0:** `Q`, `cnt` and `S_OUT` hold; `RCO` ← 0.
- **`ENB`=1, `MODO`=00 (shift left):**
  - `Q` ← {`Q`[W-2:0], `S_IN`}; `S_OUT` ← `Q`[W-1].
- **`ENB`=1, `MODO`=01 (shift right):**
  - `Q` ← {`S_IN`, `Q`[W-1:1]}; `S_OUT` ← `Q`[0].
- **`ENB`=1, `MODO`=10 (rotate left):**
  - `Q` ← {`Q`[W-2:0], `Q`[W-1]}; `S_OUT` ← `Q`[W-1]; `S_IN` is ignored.
- **`ENB`=1, `MODO`=11 (parallel load):**
  - `Q` ← `D`; `cnt` ← 0; `S_OUT` ← 0; `RCO` ← 0.
- **Counter**, for modes 00/01/10 with `ENB`=1:
  - If `cnt` = W-1: `cnt` ← 0 and `RCO` ← 1.
  - Otherwise: `cnt` ← `cnt`+1 and `RCO` ← 0.
- **Mode changes among 00/01/10** do not clear `cnt`. Shifts and rotates count toward the same word.
- **Load mid-word** discards the partial count; no `RCO` is produced for the aborted word.
- **No invalid encodings:** all four `MODO` values are defined.

## Timing
- All outputs are registered. Latency from `ENB`/`MODO`/`D`/`S_IN` sampled at edge N to the updated `Q`/`S_OUT`/`RCO` is visible after edge N.
- `RCO` is high for exactly one cycle: from the edge that performs the WIDTH-th counted shift until the next edge. A back-to-back word in progress produces its next pulse W edges later.
- Disabled cycles (`ENB`=0) stretch the word: pulse spacing is W *enabled* shift edges, not W clock edges.
- Asynchronous reset asserted mid-word clears everything within the same cycle. After `RST_N` deasserts, the first edge that sees `RST_N`=1 is the first functional edge, and a full W shifts are required before `RCO`.
- Inputs must be stable around the rising edge of `CLK`; no other handshake exists.

## Test plan
- **Reset:** with `D`=1010, `MODO`=11, `ENB`=1, drive `RST_N`=0 with no clock edge → `Q`=0000, `S_OUT`=0, `RCO`=0 immediately.
- **Load then shift left:** load 1011, then `MODO`=00, `S_IN`=0, four edges.
  - `Q` = 0110, 1100, 1000, 0000.
  - `S_OUT` = 1, 0, 1, 1.
  - `RCO`=1 only after the 4th edge, 0 on the next.
- **Rotate left:** load 1001, then `MODO`=10, four edges.
  - `Q` = 0011, 0110, 1100, 1001.
  - `S_OUT` = 1, 0, 0, 1.
  - `RCO` pulses after the 4th edge; a 5th–8th rotate produces a second pulse after the 8th.
- **Shift right with enable gaps:** from 0000, `MODO`=01, `S_IN`=1.
  - Two enabled edges → `Q`=1000, then 1100.
  - `ENB`=0 for 3 edges → `Q`=1100 held, `RCO`=0.
  - Two more enabled edges → `Q`=1110, 1111, with `RCO` pulsing after the last.
- **Load mid-word:** after 3 shifts, load 0101 (`MODO`=11) → `Q`=0101, `RCO` stays 0. The next `RCO` appears only after 4 further shifts.
- **Reset mid-word:** after 2 shifts, pulse `RST_N` low between edges → `Q`=0000 at once. After release, exactly 4 enabled shifts are needed for `RCO`; 3 must not trigger it.
